// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the scoreboarded integer register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 2;
  localparam int unsigned REG_GP   = 3;

  localparam logic [31:0] SP_RESET_DEF = 32'h0000_8000;
  localparam logic [31:0] GP_RESET_DEF = 32'h0000_8000;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits, issue handshake and
// population counter. x0 never becomes pending; flush wins over issue.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS),
  localparam int unsigned CW   = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic              flush,
  output logic              issue_ready,
  output logic [NREGS-1:0]  pending,
  output logic [CW-1:0]     pend_cnt
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             issue_zero_c;
  logic             wb_zero_c;
  logic             wb_hit_c;
  logic             accept_c;
  logic             wb_clr_c;
  logic             inc_c;
  logic             dec_c;

  // Handshake: free register, x0, or its pending bit is being retired this edge.
  assign issue_zero_c = (issue_rd == AW'(REG_ZERO));
  assign wb_zero_c    = (wb_addr == AW'(REG_ZERO));
  assign wb_hit_c     = wb_valid && (wb_addr == issue_rd);
  assign issue_ready  = issue_zero_c || !pending_q[issue_rd] || wb_hit_c;
  assign accept_c     = issue_valid && issue_ready && !issue_zero_c && !flush;
  assign wb_clr_c     = wb_valid && !wb_zero_c;

  // Next pending vector and count; a same-register issue keeps the bit owned.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    inc_c     = 1'b0;
    dec_c     = 1'b0;
    if (flush) begin
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      if (wb_clr_c) pending_d[wb_addr] = 1'b0;
      if (accept_c) pending_d[issue_rd] = 1'b1;
      inc_c = accept_c && !pending_q[issue_rd];
      dec_c = wb_clr_c && pending_q[wb_addr] && !(accept_c && (issue_rd == wb_addr));
      cnt_d = cnt_q + CW'(inc_c) - CW'(dec_c);
    end
  end

  // Scoreboard state, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending  = pending_q;
  assign pend_cnt = cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb: scoreboarded RV32 integer register file with NRD combinational
// read ports and one writeback port. Optional macro REGFILE_BYPASS_EN adds
// same-cycle writeback-to-read forwarding of data and busy.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned SP_INDEX = REG_SP,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_DEF),
  parameter int unsigned GP_INDEX = REG_GP,
  parameter logic [XLEN-1:0] GP_RESET = XLEN'(GP_RESET_DEF),
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pending     (pending),
    .pend_cnt    (pend_cnt)
  );

  // Data array: preset sp/gp at reset, writeback ignores x0 and is not gated by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (i == SP_INDEX)      regs_q[i] <= SP_RESET;
        else if (i == GP_INDEX) regs_q[i] <= GP_RESET;
        else                    regs_q[i] <= '0;
      end
    end else if (wb_valid && (wb_addr != AW'(REG_ZERO))) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read ports: x0 forced to zero, optional same-cycle forwarding from writeback.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_c;
    logic          zero_c;
    logic          byp_c;

    assign addr_c = rd_addr[k*AW +: AW];
    assign zero_c = (addr_c == AW'(REG_ZERO));
`ifdef REGFILE_BYPASS_EN
    assign byp_c  = wb_valid && (wb_addr == addr_c) && !zero_c;
`else
    assign byp_c  = 1'b0;
`endif
    assign rd_data[k*XLEN +: XLEN] = zero_c ? '0 : (byp_c ? wb_data : regs_q[addr_c]);
    assign rd_busy[k] = pending[addr_c] && !byp_c;
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors with hand-computed expectations for regfile_sb.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                issue_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [AW:0]         pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .pend_cnt    (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    flush       = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Let one rising edge pass, then return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rd(5'd0, 5'd0);
    reset = 1'b1;
    step();
    step();

    // Reset contents.
    idle();
    rd(5'd2, 5'd3);
    issue_rd = 5'd5;
    #1;
    check("rst_x2", rd_data[31:0], 32'h0000_8000);
    check("rst_x3", rd_data[63:32], 32'h0000_8000);
    check("rst_busy", 32'(rd_busy), 32'h0);
    check("rst_cnt", 32'(pend_cnt), 32'h0);
    check("rst_ready", 32'(issue_ready), 32'h1);
    rd(5'd5, 5'd0);
    #1;
    check("rst_x5", rd_data[31:0], 32'h0);
    check("rst_x0", rd_data[63:32], 32'h0);

    // Issue x5.
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    #1;
    check("x5_busy", 32'(rd_busy[0]), 32'h1);
    check("x5_cnt", 32'(pend_cnt), 32'h1);
    check("x5_ready_busy", 32'(issue_ready), 32'h0);
    // Second issue of x5 is stalled and must not change state.
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    #1;
    check("x5_stall_cnt", 32'(pend_cnt), 32'h1);

    // Writeback x5; ready is released by the same-cycle writeback.
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 32'hDEAD_BEEF;
    #1;
    check("x5_ready_wb", 32'(issue_ready), 32'h1);
    check("x5_wb_cycle_data", rd_data[31:0], BYP ? 32'hDEAD_BEEF : 32'h0);
    check("x5_wb_cycle_busy", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
    step();
    idle();
    #1;
    check("x5_data", rd_data[31:0], 32'hDEAD_BEEF);
    check("x5_busy_clr", 32'(rd_busy[0]), 32'h0);
    check("x5_cnt_clr", 32'(pend_cnt), 32'h0);

    // Issue x7, then issue+wb x7 in one cycle: data written, still pending.
    rd(5'd7, 5'd5);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    #1;
    check("x7_cnt1", 32'(pend_cnt), 32'h1);
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    wb_data  = 32'h0000_1234;
    #1;
    check("x7_ready_wb", 32'(issue_ready), 32'h1);
    step();
    idle();
    #1;
    check("x7_data", rd_data[31:0], 32'h0000_1234);
    check("x7_busy", 32'(rd_busy[0]), 32'h1);
    check("x7_cnt", 32'(pend_cnt), 32'h1);

    // x0: writeback and issue both ignored.
    rd(5'd0, 5'd7);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    wb_valid    = 1'b1;
    wb_addr     = 5'd0;
    wb_data     = 32'hFFFF_FFFF;
    #1;
    check("x0_ready", 32'(issue_ready), 32'h1);
    check("x0_rd_wb", rd_data[31:0], 32'h0);
    step();
    idle();
    #1;
    check("x0_data", rd_data[31:0], 32'h0);
    check("x0_busy", 32'(rd_busy[0]), 32'h0);
    check("x0_cnt", 32'(pend_cnt), 32'h1);

    // Issue x1, x4, x6.
    issue_valid = 1'b1;
    issue_rd = 5'd1; step();
    issue_rd = 5'd4; step();
    issue_rd = 5'd6; step();
    idle();
    rd(5'd4, 5'd8);
    #1;
    check("multi_cnt", 32'(pend_cnt), 32'h4);
    check("multi_busy4", 32'(rd_busy[0]), 32'h1);

    // Flush with concurrent wb x4 and an ignored issue of x8.
    flush       = 1'b1;
    wb_valid    = 1'b1;
    wb_addr     = 5'd4;
    wb_data     = 32'h0000_0055;
    issue_valid = 1'b1;
    issue_rd    = 5'd8;
    step();
    idle();
    #1;
    check("flush_cnt", 32'(pend_cnt), 32'h0);
    check("flush_x4", rd_data[31:0], 32'h0000_0055);
    check("flush_busy", 32'(rd_busy), 32'h0);

    // Overwrite x2, issue x10, then reset with in-flight wb x11 and issue x12.
    wb_valid = 1'b1;
    wb_addr  = 5'd2;
    wb_data  = 32'h0000_1111;
    step();
    idle();
    rd(5'd2, 5'd10);
    #1;
    check("x2_over", rd_data[31:0], 32'h0000_1111);
    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    step();
    idle();
    #1;
    check("x10_busy", 32'(rd_busy[1]), 32'h1);
    reset       = 1'b1;
    wb_valid    = 1'b1;
    wb_addr     = 5'd11;
    wb_data     = 32'h0000_0077;
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    step();
    idle();
    #1;
    check("rst2_cnt", 32'(pend_cnt), 32'h0);
    check("rst2_x2", rd_data[31:0], 32'h0000_8000);
    check("rst2_busy", 32'(rd_busy), 32'h0);
    rd(5'd11, 5'd4);
    #1;
    check("rst2_x11", rd_data[31:0], 32'h0);
    check("rst2_x4", rd_data[63:32], 32'h0);

    // Issue x9 then writeback 0xA5A5 while reading x9 in the same cycle.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    idle();
    rd(5'd9, 5'd9);
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    wb_data  = 32'h0000_A5A5;
    #1;
    check("x9_same_data", rd_data[31:0], BYP ? 32'h0000_A5A5 : 32'h0);
    check("x9_same_busy", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
    step();
    idle();
    #1;
    check("x9_next_data", rd_data[63:32], 32'h0000_A5A5);
    check("x9_next_busy", 32'(rd_busy[1]), 32'h0);
    check("x9_cnt", 32'(pend_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_sb
